usb_tx_byte_prefetch: RTL and testbench

- Downstream consumer of the TX byte counter's one-byte-ahead request level, get_tx.
- Pops bytes from the TX FIFO into a one-entry prefetch buffer, then loads them at byte boundaries into a parallel-to-serial shift register.
- Emits NRZ data LSB-first toward the bit-stuffer/encoder, and flags a clean end-of-packet or an underrun.

---
 rtl/usb_tx_pkg.sv | 6 +
 rtl/usb_tx_byte_prefetch_if.sv | 21 ++
 rtl/usb_tx_pts_sr.sv | 20 ++
 rtl/usb_tx_byte_prefetch.sv | 104 ++++++++++
 tb/tb_usb_tx_byte_prefetch.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/usb_tx_pkg.sv
// usb_tx_pkg: shared types and defaults for the USB TX byte path.
package usb_tx_pkg;
    typedef enum logic {IDLE, SHIFT} tx_pf_state_t;
    localparam logic IDLE_LEVEL = 1'b1;
    localparam int BYTE_W = 8;
endpackage

// File: rtl/usb_tx_byte_prefetch_if.sv
// usb_tx_byte_prefetch_if: FIFO, bit-timer and serial-output signals of the TX prefetch stage.
interface usb_tx_byte_prefetch_if #(parameter int DATA_WIDTH = usb_tx_pkg::BYTE_W);
    logic start;
    logic bit_strobe;
    logic get_tx;
    logic [DATA_WIDTH-1:0] fifo_rdata;
    logic fifo_empty;
    logic fifo_pop;
    logic tx_bit;
    logic tx_active;
    logic eop;
    logic underrun;
    modport master (
        output start, bit_strobe, get_tx, fifo_rdata, fifo_empty,
        input fifo_pop, tx_bit, tx_active, eop, underrun
    );
    modport slave (
        input start, bit_strobe, get_tx, fifo_rdata, fifo_empty,
        output fifo_pop, tx_bit, tx_active, eop, underrun
    );
endinterface

// File: rtl/usb_tx_pts_sr.sv
// usb_tx_pts_sr: parallel-to-serial shift register, LSB out first, idle level shifted in.
module usb_tx_pts_sr #(
    parameter int DATA_WIDTH = usb_tx_pkg::BYTE_W,
    parameter logic IDLE_LEVEL = usb_tx_pkg::IDLE_LEVEL
) (
    input logic clk,
    input logic rst,
    input logic load,
    input logic [DATA_WIDTH-1:0] load_data,
    input logic shift,
    output logic sout
);
    logic [DATA_WIDTH-1:0] sr;
    always_ff @(posedge clk) begin
        if (rst) sr <= '1;
        else if (load) sr <= load_data;
        else if (shift) sr <= {IDLE_LEVEL, sr[DATA_WIDTH-1:1]};
    end
    assign sout = sr[0];
endmodule

// File: rtl/usb_tx_byte_prefetch.sv
// usb_tx_byte_prefetch: one-byte prefetch from the TX FIFO feeding an LSB-first serializer,
// with clean end-of-packet and underrun signalling.
module usb_tx_byte_prefetch #(
    parameter int DATA_WIDTH = usb_tx_pkg::BYTE_W,
    parameter logic IDLE_LEVEL = usb_tx_pkg::IDLE_LEVEL
) (
    input logic clk,
    input logic rst,
    usb_tx_byte_prefetch_if.slave bus
);
    import usb_tx_pkg::*;
    localparam int IW = $clog2(DATA_WIDTH);
    localparam logic [IW-1:0] LAST = IW'(DATA_WIDTH - 1);
    tx_pf_state_t state, state_n;
    logic [IW-1:0] bit_idx, bit_idx_n;
    logic [DATA_WIDTH-1:0] pf_buf, pf_buf_n, ld_data;
    logic pf_valid, pf_valid_n, last_seen, last_seen_n;
    logic active, active_n, get_tx_q, req_edge;
    logic pop, load, shift, eop_n, und_n, eop_q, und_q, sr_out;
    assign req_edge = bus.get_tx & ~get_tx_q;
    usb_tx_pts_sr #(.DATA_WIDTH(DATA_WIDTH), .IDLE_LEVEL(IDLE_LEVEL)) u_sr (
        .clk(clk),
        .rst(rst),
        .load(load),
        .load_data(ld_data),
        .shift(shift),
        .sout(sr_out)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            bit_idx <= '0;
            pf_buf <= '0;
            pf_valid <= 1'b0;
            last_seen <= 1'b0;
            active <= 1'b0;
            get_tx_q <= 1'b0;
            eop_q <= 1'b0;
            und_q <= 1'b0;
        end else begin
            state <= state_n;
            bit_idx <= bit_idx_n;
            pf_buf <= pf_buf_n;
            pf_valid <= pf_valid_n;
            last_seen <= last_seen_n;
            active <= active_n;
            get_tx_q <= bus.get_tx;
            eop_q <= eop_n;
            und_q <= und_n;
        end
    end
    always_comb begin
        state_n = state;
        bit_idx_n = bit_idx;
        pf_buf_n = pf_buf;
        pf_valid_n = pf_valid;
        last_seen_n = last_seen;
        active_n = active;
        pop = 1'b0;
        load = 1'b0;
        shift = 1'b0;
        ld_data = bus.fifo_rdata;
        eop_n = 1'b0;
        und_n = 1'b0;
        if (state == IDLE) begin
            if (bus.start && !bus.fifo_empty) begin
                pop = 1'b1;
                load = 1'b1;
                bit_idx_n = '0;
                active_n = 1'b1;
                state_n = SHIFT;
            end else if (bus.start) und_n = 1'b1;
        end else begin
            if (bus.bit_strobe && bit_idx != LAST) begin
                shift = 1'b1;
                bit_idx_n = bit_idx + 1'b1;
            end else if (bus.bit_strobe && pf_valid) begin
                load = 1'b1;
                ld_data = pf_buf;
                pf_valid_n = 1'b0;
                bit_idx_n = '0;
            end else if (bus.bit_strobe) begin
                eop_n = last_seen;
                und_n = ~last_seen;
                active_n = 1'b0;
                last_seen_n = 1'b0;
                state_n = IDLE;
            end
            // a boundary load frees the buffer for a same-cycle fetch; a packet ending now takes no fetch
            if (req_edge && state_n == SHIFT && !pf_valid_n) begin
                if (!bus.fifo_empty) begin
                    pop = 1'b1;
                    pf_buf_n = bus.fifo_rdata;
                    pf_valid_n = 1'b1;
                end else last_seen_n = 1'b1;
            end
        end
    end
    assign bus.fifo_pop = pop & ~rst;
    assign bus.tx_bit = active ? sr_out : IDLE_LEVEL;
    assign bus.tx_active = active;
    assign bus.eop = eop_q;
    assign bus.underrun = und_q;
endmodule

// File: tb/tb_usb_tx_byte_prefetch.sv
// tb_usb_tx_byte_prefetch: directed scenarios for the TX byte prefetch stage with a small FIFO model.
module tb_usb_tx_byte_prefetch;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    usb_tx_byte_prefetch_if #(.DATA_WIDTH(8)) bus();
    usb_tx_byte_prefetch #(.DATA_WIDTH(8), .IDLE_LEVEL(1'b1)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );
    logic [7:0] mem [0:15];
    logic [3:0] rd = 4'd0;
    logic [3:0] wr = 4'd0;
    int pops = 0;
    int n_chk = 0;
    int n_fail = 0;
    assign bus.fifo_rdata = mem[rd];
    assign bus.fifo_empty = (rd == wr);
    always @(posedge clk) begin
        if (bus.fifo_pop) begin
            rd <= rd + 4'd1;
            pops <= pops + 1;
        end
    end
    task automatic fill(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input int n);
        mem[rd] = a;
        mem[4'(rd + 4'd1)] = b;
        mem[4'(rd + 4'd2)] = c;
        wr = 4'(rd + 4'(n));
    endtask
    task automatic cyc(input logic s, input logic bs, input logic g);
        @(negedge clk);
        bus.start = s;
        bus.bit_strobe = bs;
        bus.get_tx = g;
        #1;
    endtask
    task automatic test_reset();
        fill(8'h5A, 8'h00, 8'h00, 1);
        rst = 1'b1;
        cyc(1'b1, 1'b0, 1'b0);
        n_chk++; if (bus.fifo_pop !== 1'b0) begin n_fail++; $display("FAIL reset_pop: got %b want 0", bus.fifo_pop); end
        cyc(1'b0, 1'b0, 1'b0);
        n_chk++; if ({bus.eop, bus.underrun, bus.tx_active, bus.tx_bit} !== 4'b0001) begin n_fail++; $display("FAIL reset_outputs: got eop/und/act/bit=%b want 0001", {bus.eop, bus.underrun, bus.tx_active, bus.tx_bit}); end
        rst = 1'b0;
        wr = rd;
    endtask
    task automatic test_single();
        logic [7:0] v = 8'hA5;
        int p0 = pops;
        fill(v, 8'h00, 8'h00, 1);
        cyc(1'b1, 1'b0, 1'b0);
        n_chk++; if (bus.fifo_pop !== 1'b1) begin n_fail++; $display("FAIL single_start_pop: got %b want 1", bus.fifo_pop); end
        for (int b = 0; b < 8; b++) begin
            cyc(1'b0, 1'b0, b >= 6);
            n_chk++; if ({bus.tx_active, bus.eop, bus.tx_bit} !== {2'b10, v[b]}) begin n_fail++; $display("FAIL single_bit%0d: got act/eop/bit=%b want %b", b, {bus.tx_active, bus.eop, bus.tx_bit}, {2'b10, v[b]}); end
            cyc(1'b0, 1'b1, b >= 6);
        end
        cyc(1'b0, 1'b0, 1'b1);
        n_chk++; if ({bus.eop, bus.underrun, bus.tx_active, bus.tx_bit} !== 4'b1001) begin n_fail++; $display("FAIL single_eop: got eop/und/act/bit=%b want 1001", {bus.eop, bus.underrun, bus.tx_active, bus.tx_bit}); end
        cyc(1'b0, 1'b0, 1'b0);
        n_chk++; if (bus.eop !== 1'b0) begin n_fail++; $display("FAIL single_eop_width: got %b want 0", bus.eop); end
        n_chk++; if (pops - p0 !== 1) begin n_fail++; $display("FAIL single_pops: got %0d want 1", pops - p0); end
    endtask
    task automatic test_two_bytes();
        logic [7:0] v;
        int p0 = pops;
        fill(8'h01, 8'h80, 8'h00, 2);
        cyc(1'b1, 1'b0, 1'b0);
        for (int b = 0; b < 16; b++) begin
            v = (b < 8) ? 8'h01 : 8'h80;
            cyc(1'b0, 1'b0, (b % 8) >= 6);
            n_chk++; if ({bus.tx_active, bus.tx_bit} !== {1'b1, v[b % 8]}) begin n_fail++; $display("FAIL two_bit%0d: got act/bit=%b want %b", b, {bus.tx_active, bus.tx_bit}, {1'b1, v[b % 8]}); end
            if (b == 6 || b == 14) begin
                n_chk++; if (bus.fifo_pop !== (b == 6)) begin n_fail++; $display("FAIL two_prefetch_pop%0d: got %b want %b", b, bus.fifo_pop, b == 6); end
            end
            cyc(1'b0, 1'b1, (b % 8) >= 6);
        end
        cyc(1'b0, 1'b0, 1'b1);
        n_chk++; if ({bus.eop, bus.underrun, bus.tx_active, bus.tx_bit} !== 4'b1001) begin n_fail++; $display("FAIL two_eop: got eop/und/act/bit=%b want 1001", {bus.eop, bus.underrun, bus.tx_active, bus.tx_bit}); end
        n_chk++; if (pops - p0 !== 2) begin n_fail++; $display("FAIL two_pops: got %0d want 2", pops - p0); end
    endtask
    task automatic test_no_request();
        logic [7:0] v = 8'h3C;
        fill(v, 8'h00, 8'h00, 1);
        cyc(1'b1, 1'b0, 1'b0);
        for (int b = 0; b < 8; b++) begin
            cyc(1'b0, 1'b0, 1'b0);
            n_chk++; if ({bus.tx_active, bus.tx_bit} !== {1'b1, v[b]}) begin n_fail++; $display("FAIL noreq_bit%0d: got act/bit=%b want %b", b, {bus.tx_active, bus.tx_bit}, {1'b1, v[b]}); end
            cyc(1'b0, 1'b1, 1'b0);
        end
        cyc(1'b0, 1'b0, 1'b0);
        n_chk++; if ({bus.eop, bus.underrun, bus.tx_active, bus.tx_bit} !== 4'b0101) begin n_fail++; $display("FAIL noreq_underrun: got eop/und/act/bit=%b want 0101", {bus.eop, bus.underrun, bus.tx_active, bus.tx_bit}); end
        cyc(1'b0, 1'b0, 1'b0);
        n_chk++; if ({bus.underrun, bus.tx_active} !== 2'b00) begin n_fail++; $display("FAIL noreq_idle: got und/act=%b want 00", {bus.underrun, bus.tx_active}); end
    endtask
    task automatic test_empty_start();
        cyc(1'b1, 1'b0, 1'b0);
        n_chk++; if (bus.fifo_pop !== 1'b0) begin n_fail++; $display("FAIL empty_pop: got %b want 0", bus.fifo_pop); end
        cyc(1'b0, 1'b0, 1'b0);
        n_chk++; if ({bus.eop, bus.underrun, bus.tx_active, bus.tx_bit} !== 4'b0101) begin n_fail++; $display("FAIL empty_underrun: got eop/und/act/bit=%b want 0101", {bus.eop, bus.underrun, bus.tx_active, bus.tx_bit}); end
        cyc(1'b0, 1'b0, 1'b0);
        n_chk++; if ({bus.underrun, bus.tx_active} !== 2'b00) begin n_fail++; $display("FAIL empty_width: got und/act=%b want 00", {bus.underrun, bus.tx_active}); end
    endtask
    task automatic test_back_to_back();
        logic [7:0] v;
        int p0 = pops;
        fill(8'h11, 8'h22, 8'h33, 3);
        cyc(1'b1, 1'b0, 1'b0);
        for (int b = 0; b < 8; b++) begin
            v = 8'h11;
            cyc(1'b0, 1'b0, b == 2);
            n_chk++; if ({bus.tx_active, bus.tx_bit} !== {1'b1, v[b]}) begin n_fail++; $display("FAIL b2b_bit%0d: got act/bit=%b want %b", b, {bus.tx_active, bus.tx_bit}, {1'b1, v[b]}); end
            if (b == 2) begin
                n_chk++; if (bus.fifo_pop !== 1'b1) begin n_fail++; $display("FAIL b2b_prefetch_pop: got %b want 1", bus.fifo_pop); end
            end
            cyc(1'b0, 1'b1, b == 2 || b == 7);
            if (b == 7) begin
                n_chk++; if (bus.fifo_pop !== 1'b1) begin n_fail++; $display("FAIL b2b_boundary_pop: got %b want 1", bus.fifo_pop); end
            end
        end
        for (int b = 8; b < 24; b++) begin
            v = (b < 16) ? 8'h22 : 8'h33;
            cyc(1'b0, 1'b0, 1'b1);
            n_chk++; if ({bus.tx_active, bus.tx_bit} !== {1'b1, v[b % 8]}) begin n_fail++; $display("FAIL b2b_bit%0d: got act/bit=%b want %b", b, {bus.tx_active, bus.tx_bit}, {1'b1, v[b % 8]}); end
            cyc(1'b0, 1'b1, 1'b1);
        end
        cyc(1'b0, 1'b0, 1'b0);
        n_chk++; if ({bus.eop, bus.underrun, bus.tx_active, bus.tx_bit} !== 4'b0101) begin n_fail++; $display("FAIL b2b_end: got eop/und/act/bit=%b want 0101", {bus.eop, bus.underrun, bus.tx_active, bus.tx_bit}); end
        n_chk++; if (pops - p0 !== 3) begin n_fail++; $display("FAIL b2b_pops: got %0d want 3", pops - p0); end
    endtask
    task automatic test_mid_reset();
        logic [7:0] v = 8'h5A;
        int p0 = pops;
        fill(v, 8'h77, 8'h00, 2);
        cyc(1'b1, 1'b0, 1'b0);
        for (int b = 0; b < 3; b++) begin
            cyc(1'b0, 1'b0, 1'b0);
            cyc(1'b0, 1'b1, 1'b0);
        end
        cyc(1'b0, 1'b0, 1'b0);
        n_chk++; if ({bus.tx_active, bus.tx_bit} !== {1'b1, v[3]}) begin n_fail++; $display("FAIL mrst_bit3: got act/bit=%b want %b", {bus.tx_active, bus.tx_bit}, {1'b1, v[3]}); end
        @(negedge clk);
        rst = 1'b1;
        bus.get_tx = 1'b1;
        #1;
        n_chk++; if (bus.fifo_pop !== 1'b0) begin n_fail++; $display("FAIL mrst_pop: got %b want 0", bus.fifo_pop); end
        @(negedge clk);
        rst = 1'b0;
        bus.get_tx = 1'b0;
        #1;
        n_chk++; if ({bus.eop, bus.underrun, bus.tx_active, bus.tx_bit} !== 4'b0001) begin n_fail++; $display("FAIL mrst_outputs: got eop/und/act/bit=%b want 0001", {bus.eop, bus.underrun, bus.tx_active, bus.tx_bit}); end
        n_chk++; if (dut.pf_valid !== 1'b0) begin n_fail++; $display("FAIL mrst_pf_valid: got %b want 0", dut.pf_valid); end
        n_chk++; if (pops - p0 !== 1) begin n_fail++; $display("FAIL mrst_pops: got %0d want 1", pops - p0); end
        cyc(1'b1, 1'b0, 1'b0);
        n_chk++; if (bus.fifo_pop !== 1'b1) begin n_fail++; $display("FAIL mrst_restart_pop: got %b want 1", bus.fifo_pop); end
        cyc(1'b0, 1'b0, 1'b0);
        n_chk++; if ({bus.tx_active, bus.tx_bit} !== 2'b11) begin n_fail++; $display("FAIL mrst_restart_bit0: got act/bit=%b want 11", {bus.tx_active, bus.tx_bit}); end
    endtask
    initial begin
        bus.start = 1'b0;
        bus.bit_strobe = 1'b0;
        bus.get_tx = 1'b0;
        test_reset();
        test_single();
        test_two_bytes();
        test_no_request();
        test_empty_start();
        test_back_to_back();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
